// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the seven-segment display.
// Optional build macro BIN2BCD_SATURATE_EN: overflowed results show 9999 instead of value mod 10000.
//
// state   | meaning
// S_IDLE  | ready for a new value, outputs hold last result
// S_SHIFT | one add-3/shift iteration per clock
// S_DONE  | valid_o high for this cycle, returns to idle
module bin2bcd_seq #(
  parameter int IN_WIDTH = 14
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                valid_i,
  input  logic [IN_WIDTH-1:0] bin_i,
  output logic                ready_o,
  output logic [3:0][3:0]     bcd_o,
  output logic                overflow_o,
  output logic                valid_o
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int CW = 5;

  state_t                r_state;
  logic [IN_WIDTH-1:0]   r_shift;
  logic [19:0]           r_scratch;
  logic [CW-1:0]         r_bits_left;
  logic [3:0][3:0]       r_bcd;
  logic                  r_ovf;
  logic                  r_valid;

  logic [19:0]           w_adj;
  logic [19:0]           w_scratch_nxt;
  logic                  w_ovf_nxt;
  logic [15:0]           w_bcd_nxt;

  always_comb begin
    w_adj = '0;
    for (int d = 0; d < 5; d++) begin
      if (r_scratch[d*4 +: 4] >= 4'd5)
        w_adj[d*4 +: 4] = r_scratch[d*4 +: 4] + 4'd3;
      else
        w_adj[d*4 +: 4] = r_scratch[d*4 +: 4];
    end
  end

  assign w_scratch_nxt = {w_adj[18:0], r_shift[IN_WIDTH-1]};
  // w_adj[19] stays 0 for inputs up to 16 bits; folding it in keeps every bit consumed
  assign w_ovf_nxt     = (|w_scratch_nxt[19:16]) | w_adj[19];

`ifdef BIN2BCD_SATURATE_EN
  assign w_bcd_nxt = w_ovf_nxt ? 16'h9999 : w_scratch_nxt[15:0];
`else
  assign w_bcd_nxt = w_scratch_nxt[15:0];
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_scratch   <= '0;
      r_bits_left <= '0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (valid_i) begin
            r_shift     <= bin_i;
            r_scratch   <= '0;
            r_bits_left <= CW'(IN_WIDTH - 1);
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_scratch_nxt;
          r_shift   <= {r_shift[IN_WIDTH-2:0], 1'b0};
          if (r_bits_left == '0) begin
            r_bcd   <= w_bcd_nxt;
            r_ovf   <= w_ovf_nxt;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_bits_left <= r_bits_left - 1'b1;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o    = (r_state == S_IDLE) && reset_n_i;
  assign bcd_o      = r_bcd;
  assign overflow_o = r_ovf;
  assign valid_o    = r_valid;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized and directed bench for bin2bcd_seq against an arithmetic reference model.
module tb_bin2bcd_seq;
  localparam int W = 14;

  logic           clk = 1'b0;
  logic           reset_n_i;
  logic           valid_i;
  logic [W-1:0]   bin_i;
  logic           ready_o;
  logic [3:0][3:0] bcd_o;
  logic           overflow_o;
  logic           valid_o;

  int checks = 0;
  int failures = 0;

  bin2bcd_seq #(.IN_WIDTH(W)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .valid_i   (valid_i),
    .bin_i     (bin_i),
    .ready_o   (ready_o),
    .bcd_o     (bcd_o),
    .overflow_o(overflow_o),
    .valid_o   (valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_bcd(input int v);
    int m;
    logic [3:0] d0, d1, d2, d3;
`ifdef BIN2BCD_SATURATE_EN
    if (v > 9999) return 16'h9999;
`endif
    m  = v % 10000;
    d3 = 4'(m / 1000);
    d2 = 4'((m / 100) % 10);
    d1 = 4'((m / 10) % 10);
    d0 = 4'(m % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: a conversion accepted at an edge publishes W edges later, idle one edge after that.
  bit          m_known = 0;
  int          m_left = 0;
  int          m_val = 0;
  logic [15:0] m_bcd = '0;
  logic        m_ovf = 1'b0;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_n_i) begin
      m_known = 1;
      m_left  = 0;
      m_bcd   = '0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
    end else if (m_known) begin
      if (m_left > 0) begin
        m_left--;
        m_valid = (m_left == 1);
        if (m_left == 1) begin
          m_bcd = exp_bcd(m_val);
          m_ovf = (m_val > 9999);
        end
      end else if (valid_i) begin
        m_val   = int'(bin_i);
        m_left  = W + 1;
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("mon_valid", 32'(valid_o), 32'(m_valid));
      chk("mon_bcd", 32'(bcd_o), 32'(m_bcd));
      chk("mon_ovf", 32'(overflow_o), 32'(m_ovf));
      chk("mon_ready", 32'(ready_o), 32'((m_left == 0) && reset_n_i));
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready_o && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o && n < 40);
    chk({tag, "_valid_seen"}, 32'(valid_o), 32'd1);
  endtask

  task automatic convert(input int v, input logic [15:0] eb, input logic eo, input string tag);
    int n;
    wait_ready(tag);
    valid_i = 1'b1;
    bin_i   = W'(v);
    tick();
    valid_i = 1'b0;
    wait_valid(tag, n);
    chk({tag, "_latency"}, 32'(n), 32'(W + 1));
    chk({tag, "_bcd"}, 32'(bcd_o), 32'(eb));
    chk({tag, "_ovf"}, 32'(overflow_o), 32'(eo));
  endtask

  initial begin
    int acc;
    int n;
    bit seen;
    int v;

    reset_n_i = 1'b0;
    valid_i   = 1'b1;
    bin_i     = W'(123);
    repeat (3) begin
      tick();
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_bcd", 32'(bcd_o), 32'h0000);
      chk("rst_ovf", 32'(overflow_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
    end
    valid_i   = 1'b0;
    reset_n_i = 1'b1;
    tick();
    chk("post_rst_ready", 32'(ready_o), 32'd1);

    convert(1234, 16'h1234, 1'b0, "basic");
    tick();
    chk("basic_ready_after", 32'(ready_o), 32'd1);
    convert(0, 16'h0000, 1'b0, "zero");
    convert(9999, 16'h9999, 1'b0, "max_dec");
`ifdef BIN2BCD_SATURATE_EN
    convert(12345, 16'h9999, 1'b1, "ovf_12345");
    convert(16383, 16'h9999, 1'b1, "ovf_16383");
`else
    convert(12345, 16'h2345, 1'b1, "ovf_12345");
    convert(16383, 16'h6383, 1'b1, "ovf_16383");
`endif
    convert(10000, exp_bcd(10000), 1'b1, "ovf_10000");

    // Handshake: valid held high, second value must wait for the idle cycle
    wait_ready("hs");
    valid_i = 1'b1;
    bin_i   = W'(42);
    tick();
    bin_i = W'(7);
    acc   = -1;
    for (int i = 1; i <= 40 && acc < 0; i++) begin
      if (ready_o) begin
        acc = i;
        chk("hs_hold_42", 32'(bcd_o), 32'h0042);
      end
      tick();
    end
    valid_i = 1'b0;
    chk("hs_accept_edge", 32'(acc), 32'd16);
    wait_valid("hs2", n);
    chk("hs_bcd_7", 32'(bcd_o), 32'h0007);

    // Abort mid-conversion
    convert(1111, 16'h1111, 1'b0, "pre_abort");
    wait_ready("abort");
    valid_i = 1'b1;
    bin_i   = W'(5678);
    tick();
    valid_i = 1'b0;
    repeat (4) tick();
    reset_n_i = 1'b0;
    tick();
    chk("abort_bcd", 32'(bcd_o), 32'h0000);
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_ovf", 32'(overflow_o), 32'd0);
    chk("abort_ready_low", 32'(ready_o), 32'd0);
    reset_n_i = 1'b1;
    tick();
    chk("abort_idle", 32'(ready_o), 32'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    convert(5678, 16'h5678, 1'b0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      v = 9990 + i;
      convert(v, exp_bcd(v), v > 9999, "edge_sweep");
    end

    // Random traffic: optional gaps, held-valid bursts; the model checks every cycle
    for (int i = 0; i < 400; i++) begin
      valid_i = 1'b1;
      bin_i   = W'($urandom_range(0, 16383));
      tick();
      if ($urandom_range(0, 3) == 0) begin
        valid_i = 1'b0;
        repeat ($urandom_range(1, 20)) tick();
      end
    end
    valid_i = 1'b0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
